// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and constants for the wait-state memory responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [31:0] ERR_RDATA = 32'h0;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_responder_sp_ram.sv
// mem_responder_sp_ram: single-port RAM, synchronous write and synchronous read.
module mem_responder_sp_ram #(
    parameter int DEPTH = 64,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with req/ready handshake and WAIT_CYCLES wait states.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0] idx;
    logic [31:0] wd_q, ram_q;
    logic we_q, use_ram, bad, access;
    assign bad = Adr[1:0] != 2'b0 || {2'b0, Adr[31:2]} >= 32'(DEPTH_WORDS);
    assign access = state == WAIT && cnt == '0;
    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE ? (req ? (bad ? RESP : WAIT) : IDLE) :
                  state == WAIT ? (access ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            wd_q <= '0;
            we_q <= 1'b0;
            use_ram <= 1'b0;
            ready <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            ready <= state_n == RESP;
            err <= state == IDLE && req && bad;
            if (state == IDLE && req) begin
                idx <= Adr[AW+1:2];
                wd_q <= WriteData;
                we_q <= we;
                cnt <= CNT_W'(WAIT_CYCLES);
                if (bad) use_ram <= 1'b0;
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (access && !we_q) use_ram <= 1'b1;
        end
    // RAM read port only fires on read accesses, so its output doubles as the held ReadData
    assign ReadData = use_ram ? ram_q : ERR_RDATA;
    mem_responder_sp_ram #(.DEPTH(DEPTH_WORDS)) sp_ram (
        .clk(clk),
        .en(access),
        .we(we_q),
        .addr(idx),
        .wdata(wd_q),
        .rdata(ram_q)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder, WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_mem_responder;
    typedef struct {
        int          cyc;
        logic        e;
        logic [31:0] rd;
        bit          chk;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req [2];
    logic we [2];
    logic [31:0] adr [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic rdy [2];
    logic er [2];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q0[$], q1[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(rst_n), .req(req[0]), .we(we[0]), .Adr(adr[0]),
        .WriteData(wd[0]), .ReadData(rd[0]), .ready(rdy[0]), .err(er[0])
    );
    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(rst_n), .req(req[1]), .we(we[1]), .Adr(adr[1]),
        .WriteData(wd[1]), .ReadData(rd[1]), .ready(rdy[1]), .err(er[1])
    );
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask
    task automatic chk_resp(input int d, input exp_t e);
        cmp($sformatf("latency%0d", d), cyc, e.cyc);
        cmp($sformatf("err%0d", d), {31'b0, er[d]}, {31'b0, e.e});
        if (e.chk) cmp($sformatf("rdata%0d", d), rd[d], e.rd);
    endtask
    always @(negedge clk) begin
        if (rdy[0]) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready0: got ready=1 expected 0 (cycle %0d)", cyc);
            end else chk_resp(0, q0.pop_front());
        end
        if (rdy[1]) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready1: got ready=1 expected 0 (cycle %0d)", cyc);
            end else chk_resp(1, q1.pop_front());
        end
    end
    // Called at a negedge; returns at the negedge where ready is seen
    task automatic tx(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                      input bit bad, input logic [31:0] exp_rd, input bit chk, input bit hold);
        int t0, n;
        exp_t e;
        t0 = rdy[d] ? cyc + 2 : cyc + 1;
        e.cyc = t0 + (bad ? 0 : (d == 0 ? 3 : 1));
        e.e = bad;
        e.rd = exp_rd;
        e.chk = chk;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        req[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (cyc >= t0 && !rdy[d]) begin
                adr[d] = ~a; wd[d] = ~data; we[d] = ~w;
            end
        end while (!rdy[d] && n < 40);
        if (!rdy[d]) begin
            checks++; errors++;
            $display("FAIL timeout%0d: got no ready expected ready by cycle %0d", d, e.cyc);
        end
        if (!hold) req[d] = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; we[i] = 1'b1; adr[i] = 32'h10; wd[i] = 32'hFFFF_FFFF;
        end
        #1 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                cmp("reset_rd", rd[i], 32'h0);
                cmp("reset_ready", {31'b0, rdy[i]}, 32'h0);
                cmp("reset_err", {31'b0, er[i]}, 32'h0);
            end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tx(0, 1, 32'h10, 32'hCAFE_F00D, 0, 0, 0, 0);
        tx(0, 0, 32'h10, 32'h0, 0, 32'hCAFE_F00D, 1, 0);
        tx(0, 1, 32'h0, 32'h1111_1111, 0, 0, 0, 1);
        tx(0, 1, 32'h4, 32'h2222_2222, 0, 0, 0, 1);
        tx(0, 0, 32'h0, 32'h0, 0, 32'h1111_1111, 1, 1);
        tx(0, 0, 32'h4, 32'h0, 0, 32'h2222_2222, 1, 0);
        repeat (3) begin
            @(negedge clk);
            cmp("rd_hold", rd[0], 32'h2222_2222);
        end
        tx(0, 0, 32'h2, 32'h0, 1, 32'h0, 1, 0);
        tx(0, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h0, 1, 0);
        tx(0, 0, 32'h0, 32'h0, 0, 32'h1111_1111, 1, 0);
        tx(0, 1, 32'h8, 32'h5555_5555, 0, 0, 0, 0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h8; wd[0] = 32'hAAAA_AAAA;
        @(negedge clk);
        rst_n = 1'b0;
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        cmp("abort_rd", rd[0], 32'h0);
        tx(0, 0, 32'h8, 32'h0, 0, 32'h5555_5555, 1, 0);
        tx(1, 1, 32'h10, 32'h1234_5678, 0, 0, 0, 0);
        tx(1, 0, 32'h10, 32'h0, 0, 32'h1234_5678, 1, 0);
        tx(1, 0, 32'hFC, 32'h0, 0, 32'h0, 0, 0);
        tx(1, 0, 32'h101, 32'h0, 1, 32'h0, 1, 0);
        repeat (4) @(negedge clk);
        cmp("q0_empty", q0.size(), 32'h0);
        cmp("q1_empty", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
